nios_i2c_acc_multi_timer: RTL and testbench



---
 rtl/nios_i2c_acc_multi_timer_if.sv | 29 ++
 rtl/nios_i2c_acc_multi_timer.sv | 142 ++++++++++++++
 tb/tb_nios_i2c_acc_multi_timer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_i2c_acc_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// address: [1:0] register, upper bits channel; readdata is registered by the slave.
interface nios_i2c_acc_multi_timer_if #(
    parameter int NUM_CH = 2
) ();
    localparam int AW = $clog2(NUM_CH) + 2;

    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_i2c_acc_multi_timer.sv
// NUM_CH independent prescaled down-counters behind an Avalon-MM slave.
// Ports: clk, reset_n (async low), bus (slave modport), irq, irq_vec.
module nios_i2c_acc_multi_timer #(
    parameter int NUM_CH         = 2,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nios_i2c_acc_multi_timer_if.slave bus,
    output logic                      irq,
    output logic [NUM_CH-1:0]         irq_vec
);
    localparam int CW = COUNTER_WIDTH;
    localparam int PW = PRESCALE_WIDTH;
    localparam logic [CW-1:0] RST_PERIOD = CW'(DEFAULT_PERIOD);

    logic [CW-1:0] cnt_q    [NUM_CH];
    logic [CW-1:0] period_q [NUM_CH];
    logic [CW-1:0] snap_q   [NUM_CH];
    logic [PW-1:0] pc_q     [NUM_CH];
    logic [PW-1:0] presc_q  [NUM_CH];
    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] to_q;
    logic [NUM_CH-1:0] ito_q;
    logic [NUM_CH-1:0] cont_q;

    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tmo;
    logic [31:0]       ch_idx;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic [31:0]       rd_next;
    logic              unused_ok;

    assign ch_idx    = 32'(bus.address >> 2);
    assign reg_sel   = bus.address[1:0];
    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign unused_ok = ^bus.writedata;

    always_comb begin
        ch_wr = '0;
        tick  = '0;
        tmo   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = wr_en && (ch_idx == 32'(i));
            tick[i]  = run_q[i] && (pc_q[i] == presc_q[i]);
            tmo[i]   = tick[i] && (cnt_q[i] == '0);
        end
    end

    // Later assignments in the loop body take priority: register writes
    // override counting, and a timeout set overrides a STATUS clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= RST_PERIOD;
                period_q[i] <= RST_PERIOD;
                snap_q[i]   <= '0;
                pc_q[i]     <= '0;
                presc_q[i]  <= '0;
            end
            run_q  <= '0;
            to_q   <= '0;
            ito_q  <= '0;
            cont_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick[i]) begin
                    cnt_q[i] <= tmo[i] ? period_q[i]
                                       : cnt_q[i] - CW'(1);
                end
                if (run_q[i]) begin
                    pc_q[i] <= tick[i] ? '0 : pc_q[i] + PW'(1);
                end
                if (tmo[i] && !cont_q[i]) begin
                    run_q[i] <= 1'b0;
                end
                if (ch_wr[i]) begin
                    unique case (reg_sel)
                        2'd0: to_q[i] <= 1'b0;
                        2'd1: begin
                            ito_q[i]   <= bus.writedata[0];
                            cont_q[i]  <= bus.writedata[1];
                            presc_q[i] <= bus.writedata[8 +: PW];
                            if (bus.writedata[2]) begin
                                run_q[i] <= 1'b1;
                                pc_q[i]  <= '0;
                            end else if (bus.writedata[3]) begin
                                run_q[i] <= 1'b0;
                            end
                        end
                        2'd2: begin
                            period_q[i] <= bus.writedata[CW-1:0];
                            cnt_q[i]    <= bus.writedata[CW-1:0];
                            run_q[i]    <= 1'b0;
                            pc_q[i]     <= '0;
                        end
                        2'd3: snap_q[i] <= cnt_q[i];
                        default: ;
                    endcase
                end
                if (tmo[i]) begin
                    to_q[i] <= 1'b1;
                end
            end
        end
    end

    // Channels beyond NUM_CH never match and fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 32'(i)) begin
                unique case (reg_sel)
                    2'd0: rd_next = {30'b0, run_q[i], to_q[i]};
                    2'd1: begin
                        rd_next[8 +: PW] = presc_q[i];
                        rd_next[1]       = cont_q[i];
                        rd_next[0]       = ito_q[i];
                    end
                    2'd2: rd_next = 32'(period_q[i]);
                    2'd3: rd_next = 32'(snap_q[i]);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
        end
    end

    assign irq_vec = to_q & ito_q;
    assign irq     = |irq_vec;
endmodule

// File: tb/tb_nios_i2c_acc_multi_timer.sv
// Bench for nios_i2c_acc_multi_timer: directed scenarios plus random bus
// traffic, all checked every cycle against a register-level reference model.
module tb_nios_i2c_acc_multi_timer;
    localparam int NCH = 3;
    localparam int DEF = 49999;
    localparam int AW  = $clog2(NCH) + 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           irq;
    logic [NCH-1:0] irq_vec;

    nios_i2c_acc_multi_timer_if #(.NUM_CH(NCH)) bus ();

    nios_i2c_acc_multi_timer #(
        .NUM_CH(NCH),
        .COUNTER_WIDTH(32),
        .PRESCALE_WIDTH(8),
        .DEFAULT_PERIOD(DEF)
    ) u_dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .irq(irq),
        .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int unsigned m_cnt  [NCH];
    int unsigned m_per  [NCH];
    int unsigned m_snap [NCH];
    int          m_pc   [NCH];
    int          m_presc[NCH];
    bit          m_run  [NCH];
    bit          m_to   [NCH];
    bit          m_ito  [NCH];
    bit          m_cont [NCH];

    logic [31:0] exp_rd;
    logic [31:0] rd_val;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(int ch, int r);
        if (ch >= NCH) return 32'd0;
        case (r)
            0: return {30'd0, m_run[ch], m_to[ch]};
            1: return (32'(m_presc[ch]) << 8) | (32'(m_cont[ch]) << 1)
                      | 32'(m_ito[ch]);
            2: return m_per[ch];
            default: return m_snap[ch];
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = DEF; m_per[c] = DEF; m_snap[c] = 0;
            m_pc[c] = 0; m_presc[c] = 0;
            m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
        end
    endtask

    // One clock edge of the register map as software sees it.
    task automatic model_step();
        int ach;
        int r;
        bit we;
        logic [31:0] wd;
        ach = int'(bus.address >> 2);
        r   = int'(bus.address[1:0]);
        we  = bus.chipselect && !bus.write_n;
        wd  = bus.writedata;
        exp_rd = m_read(ach, r);
        for (int c = 0; c < NCH; c++) begin
            bit tk;
            bit tmo;
            bit hit;
            int unsigned old;
            old = m_cnt[c];
            tk  = m_run[c] && (m_pc[c] == m_presc[c]);
            tmo = tk && (old == 0);
            hit = we && (ach == c);
            if (m_run[c]) m_pc[c] = tk ? 0 : ((m_pc[c] + 1) & 255);
            if (tk) m_cnt[c] = (old == 0) ? m_per[c] : old - 1;
            if (tmo && !m_cont[c]) m_run[c] = 0;
            if (hit) begin
                case (r)
                    0: m_to[c] = 0;
                    1: begin
                        m_ito[c]   = wd[0];
                        m_cont[c]  = wd[1];
                        m_presc[c] = int'(wd[15:8]);
                        if (wd[2]) begin
                            m_run[c] = 1; m_pc[c] = 0;
                        end else if (wd[3]) begin
                            m_run[c] = 0;
                        end
                    end
                    2: begin
                        m_per[c] = wd; m_cnt[c] = wd;
                        m_run[c] = 0; m_pc[c] = 0;
                    end
                    default: m_snap[c] = old;
                endcase
            end
            if (tmo) m_to[c] = 1;
        end
    endtask

    task automatic step();
        logic [NCH-1:0] ev;
        @(posedge clk);
        model_step();
        #1;
        rd_val = bus.readdata;
        ev = '0;
        for (int c = 0; c < NCH; c++) ev[c] = m_to[c] & m_ito[c];
        check("readdata", rd_val, exp_rd);
        check("irq_vec", 32'(irq_vec), 32'(ev));
        check("irq", 32'(irq), 32'(|ev));
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic wr(int ch, int r, logic [31:0] d);
        bus.address    = AW'(ch * 4 + r);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(int ch, int r);
        bus.address = AW'(ch * 4 + r);
        step();
    endtask

    task automatic wait_irq(int idx, int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!irq_vec[idx] && n < maxc);
        if (!irq_vec[idx]) check("wait_irq_bound", 32'(irq_vec[idx]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset_n        = 1'b0;
        model_reset();
        #12;
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        #10;
        reset_n = 1'b1;

        for (int c = 0; c < NCH; c++) begin
            rd(c, 2); check("rst_period", rd_val, DEF);
            rd(c, 0); check("rst_status", rd_val, 32'd0);
            rd(c, 1); check("rst_control", rd_val, 32'd0);
        end

        wr(0, 2, 9);
        wr(0, 1, 32'h7);
        wait_irq(0, 50, n);
        check("ch0_first_to_cycles", n, 10);
        check("ch0_irq_high", 32'(irq), 32'd1);
        wr(0, 0, 0);
        check("ch0_irq_cleared", 32'(irq_vec[0]), 32'd0);
        wait_irq(0, 50, n);
        check("ch0_second_to_cycles", n, 9);

        wr(1, 2, 3);
        wr(1, 1, (32'd4 << 8) | 32'h5);
        wait_irq(1, 100, n);
        check("ch1_oneshot_cycles", n, 20);
        rd(1, 0);
        check("ch1_status_stopped", rd_val, 32'd1);
        wr(1, 3, 0); rd(1, 3);
        check("ch1_counter_reloaded", rd_val, 32'd3);
        idle(30);
        wr(1, 3, 0); rd(1, 3);
        check("ch1_counter_held", rd_val, 32'd3);

        k = 0;
        while (m_cnt[0] != 5 && k < 20) begin
            step();
            k++;
        end
        wr(0, 2, 100);
        wr(0, 3, 0); rd(0, 3);
        check("ch0_period_reload", rd_val, 32'd100);
        rd(0, 0);
        check("ch0_run_cleared", (rd_val >> 1) & 32'd1, 32'd0);
        idle(20);
        wr(0, 3, 0); rd(0, 3);
        check("ch0_counter_frozen", rd_val, 32'd100);

        wr(0, 2, 4);
        wr(0, 0, 0);
        wr(0, 1, 32'h7);
        idle(4);
        wr(0, 0, 0);
        rd(0, 0);
        check("status_vs_timeout", rd_val & 32'd1, 32'd1);

        wr(2, 1, 32'hC);
        rd(2, 0);
        check("start_wins_stop", rd_val, 32'd2);

        wr(2, 2, 1000);
        wr(2, 1, 32'h4);
        idle(258);
        wr(2, 3, 0);
        rd(2, 3);
        check("snapshot_742", rd_val, 32'd742);

        for (int r = 0; r < 4; r++) begin
            rd(3, r);
            check("bad_ch_read", rd_val, 32'd0);
        end
        wr(3, 2, 5);
        wr(3, 1, 32'h4);
        wr(3, 0, 0);
        rd(2, 2); check("bad_ch_no_effect_2", rd_val, 32'd1000);
        rd(0, 2); check("bad_ch_no_effect_0", rd_val, 32'd4);
        rd(1, 2); check("bad_ch_no_effect_1", rd_val, 32'd3);

        for (int it = 0; it < 600; it++) begin
            int ch;
            int r;
            int op;
            logic [31:0] d;
            ch = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 3));
            case (r)
                2: d = $urandom_range(0, 15);
                1: d = ($urandom_range(0, 3) << 8) | $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            case (op)
                0, 1: idle(1);
                2: rd(ch, r);
                default: wr(ch, r, d);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
